pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter CYC_W, default 32, width of the cycle counter.
REQ-002 Parameter EVT_W, default 16, width of the jump, branch and stall event counters.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 load_use  input  1  ID-stage instruction reads a register loaded by the EX-stage instruction.
REQ-006 jmp  input  1  ID-stage instruction is an unconditional jump (j/jal/jr).
REQ-007 br_taken  input  1  EX-stage branch resolved taken.
REQ-008 sys_halt  input  1  EX-stage syscall requests halt.
REQ-009 go  input  1  resume request, level input from a board button.
REQ-010 pc_en  output  1  PC register load enable.
REQ-011 ifid_en  output  1  IF/ID register load enable.
REQ-012 ifid_flush  output  1  IF/ID register is cleared to a bubble on the next edge.
REQ-013 idex_flush  output  1  ID/EX register is cleared to a bubble on the next edge.
REQ-014 halted  output  1  controller is in HALT.
REQ-015 cyc_cnt  output  CYC_W  count of RUN cycles.
REQ-016 jmp_cnt  output  EVT_W  count of accepted jumps.
REQ-017 br_cnt  output  EVT_W  count of accepted taken branches.
REQ-018 stall_cnt  output  EVT_W  count of load-use stall cycles.

Function
REQ-019 The FSM SHALL have two states, RUN and HALT; the state register and the kill_q, go_q and counter registers are the only sequential state.
REQ-020 The control outputs SHALL be combinational from the state, the inputs and kill_q, with zero-cycle latency.
REQ-021 Event priority in RUN SHALL be: sys_halt > br_taken > jmp > load_use.
REQ-022 In RUN with no event: pc_en=1, ifid_en=1, ifid_flush=0, idex_flush=0.
REQ-023 sys_halt in RUN: pc_en=0, ifid_en=0, both flushes=0; the next state SHALL be HALT.
REQ-024 br_taken in RUN: pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1; br_cnt SHALL increment.
REQ-025 jmp in RUN without br_taken: pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=0; jmp_cnt SHALL increment.
REQ-026 load_use alone in RUN: pc_en=0, ifid_en=0, idex_flush=1, ifid_flush=0; stall_cnt SHALL increment.
REQ-027 kill_q SHALL be set for exactly one cycle after any cycle with ifid_flush=1.
REQ-028 While kill_q=1, jmp and load_use SHALL be ignored, because they originate from a squashed instruction; back-to-back jumps therefore cost one bubble each, never two.
REQ-029 br_taken and sys_halt SHALL NOT be masked by kill_q.
REQ-030 HALT: pc_en=0, ifid_en=0, both flushes=0, halted=1; all counters SHALL hold.
REQ-031 go_q SHALL register go every cycle.
REQ-032 HALT SHALL exit to RUN only on a rising go edge (go=1 and go_q=0); a held go SHALL resume only once.
REQ-033 During the HALT-exit cycle the outputs SHALL be as in HALT; normal operation starts the following cycle.
REQ-034 cyc_cnt SHALL increment in every RUN cycle, including stall and flush cycles.
REQ-035 All counters SHALL wrap modulo 2^width without saturating or flagging.
REQ-036 Simultaneous br_taken and load_use: the branch flush SHALL win and stall_cnt SHALL NOT increment.

Reset
REQ-037 While rst=1: state=RUN, kill_q=0, go_q=0, all counters=0.
REQ-038 While rst=1 the outputs SHALL be pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1, halted=0.
REQ-039 rst SHALL override every other input, including when asserted mid-halt or mid-flush.

Structure
REQ-040 A shared package SHALL hold the state enum (RUN, HALT) and the default values of CYC_W and EVT_W.
REQ-041 A single sub-module, evt_counter (parameterised width, synchronous clear, enable, wrap), SHALL be instantiated four times.

Verification
REQ-042 Reset test: rst for 2 cycles then idle for 10 -> cyc_cnt=10, other counters=0, pc_en=1.
REQ-043 Back-to-back jumps: jmp=1 for 2 cycles -> ifid_flush high in cycle 1 only, jmp_cnt=1.
REQ-044 Branch with load-use: br_taken=1 and load_use=1 in the same cycle -> both flushes=1, pc_en=1, br_cnt=1, stall_cnt=0.
REQ-045 Halt and resume: sys_halt pulse, go held high for 5 cycles -> halted=1 until the first go edge, a single resume, counters frozen during HALT.
REQ-046 Counter wrap: with EVT_W=4, 17 load-use stalls -> stall_cnt=1.
REQ-047 Reset mid-halt: rst asserted in HALT -> state RUN, halted=0, all counters 0 on the next cycle.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and default widths for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam int CYC_W_DEF = 32;
  localparam int EVT_W_DEF = 16;

endpackage

// File: rtl/pipe_hazard_ctrl_evt_counter.sv
// Free-running event counter with synchronous clear and enable; wraps modulo 2^W.
module evt_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (clr)     count <= '0;
    else if (en) count <= count + W'(1);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/halt controller for a 5-stage pipeline with event counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CYC_W = CYC_W_DEF,
  parameter int EVT_W = EVT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use,
  input  logic             jmp,
  input  logic             br_taken,
  input  logic             sys_halt,
  input  logic             go,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [CYC_W-1:0] cyc_cnt,
  output logic [EVT_W-1:0] jmp_cnt,
  output logic [EVT_W-1:0] br_cnt,
  output logic [EVT_W-1:0] stall_cnt
);

  state_t state_q, state_d;
  logic   kill_q, go_q;
  logic   cyc_inc, jmp_inc, br_inc, stall_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      kill_q  <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= ifid_flush;
      go_q    <= go;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    halted     = 1'b0;
    cyc_inc    = 1'b0;
    jmp_inc    = 1'b0;
    br_inc     = 1'b0;
    stall_inc  = 1'b0;

    if (rst) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (state_q == HALT) begin
      halted = 1'b1;
      if (go && !go_q) state_d = RUN;
    end else begin
      cyc_inc = 1'b1;
      pc_en   = 1'b1;
      ifid_en = 1'b1;
      // jmp/load_use right after a flush come from the squashed instruction.
      if (sys_halt) begin
        pc_en   = 1'b0;
        ifid_en = 1'b0;
        state_d = HALT;
      end else if (br_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        br_inc     = 1'b1;
      end else if (jmp && !kill_q) begin
        ifid_flush = 1'b1;
        jmp_inc    = 1'b1;
      end else if (load_use && !kill_q) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
        stall_inc  = 1'b1;
      end
    end
  end

  evt_counter #(.W(CYC_W)) u_cyc_cnt (
    .clk(clk), .clr(rst), .en(cyc_inc), .count(cyc_cnt)
  );

  evt_counter #(.W(EVT_W)) u_jmp_cnt (
    .clk(clk), .clr(rst), .en(jmp_inc), .count(jmp_cnt)
  );

  evt_counter #(.W(EVT_W)) u_br_cnt (
    .clk(clk), .clr(rst), .en(br_inc), .count(br_cnt)
  );

  evt_counter #(.W(EVT_W)) u_stall_cnt (
    .clk(clk), .clr(rst), .en(stall_inc), .count(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl, built with EVT_W=4 so event counters wrap quickly.
module tb_pipe_hazard_ctrl;

  localparam int CYC_W = 32;
  localparam int EVT_W = 4;

  logic             clk = 1'b0;
  logic             rst, load_use, jmp, br_taken, sys_halt, go;
  logic             pc_en, ifid_en, ifid_flush, idex_flush, halted;
  logic [CYC_W-1:0] cyc_cnt;
  logic [EVT_W-1:0] jmp_cnt, br_cnt, stall_cnt;

  int checks   = 0;
  int failures = 0;

  pipe_hazard_ctrl #(.CYC_W(CYC_W), .EVT_W(EVT_W)) dut (
    .clk(clk), .rst(rst), .load_use(load_use), .jmp(jmp), .br_taken(br_taken),
    .sys_halt(sys_halt), .go(go), .pc_en(pc_en), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .halted(halted),
    .cyc_cnt(cyc_cnt), .jmp_cnt(jmp_cnt), .br_cnt(br_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one edge and leave a margin before the next drive/sample.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag, input int c, input int j, input int b, input int s);
    check({tag, ".cyc"},   cyc_cnt,         32'(c));
    check({tag, ".jmp"},   32'(jmp_cnt),    32'(j));
    check({tag, ".br"},    32'(br_cnt),     32'(b));
    check({tag, ".stall"}, 32'(stall_cnt),  32'(s));
  endtask

  initial begin
    rst = 1'b1; load_use = 1'b0; jmp = 1'b0; br_taken = 1'b0; sys_halt = 1'b0; go = 1'b0;

    // Reset outputs and counters
    #1;
    check("rst.pc_en",      32'(pc_en),      32'd0);
    check("rst.ifid_en",    32'(ifid_en),    32'd0);
    check("rst.ifid_flush", 32'(ifid_flush), 32'd1);
    check("rst.idex_flush", 32'(idex_flush), 32'd1);
    check("rst.halted",     32'(halted),     32'd0);
    tick(); tick();
    check_cnt("rst", 0, 0, 0, 0);

    // Idle for 10 cycles
    rst = 1'b0;
    repeat (10) tick();
    check_cnt("idle", 10, 0, 0, 0);
    check("idle.pc_en",      32'(pc_en),      32'd1);
    check("idle.ifid_flush", 32'(ifid_flush), 32'd0);

    // Back-to-back jumps: only the first is accepted
    jmp = 1'b1; #1;
    check("jmp1.ifid_flush", 32'(ifid_flush), 32'd1);
    check("jmp1.idex_flush", 32'(idex_flush), 32'd0);
    check("jmp1.pc_en",      32'(pc_en),      32'd1);
    tick();
    check("jmp2.ifid_flush", 32'(ifid_flush), 32'd0);
    check("jmp2.pc_en",      32'(pc_en),      32'd1);
    tick();
    jmp = 1'b0; #1;
    check_cnt("jmp", 12, 1, 0, 0);

    // Branch and load-use together: branch wins
    br_taken = 1'b1; load_use = 1'b1; #1;
    check("brlu.ifid_flush", 32'(ifid_flush), 32'd1);
    check("brlu.idex_flush", 32'(idex_flush), 32'd1);
    check("brlu.pc_en",      32'(pc_en),      32'd1);
    tick();
    br_taken = 1'b0; #1;
    check_cnt("brlu", 13, 1, 1, 0);
    check("kill.lu_masked.pc_en", 32'(pc_en),      32'd1);
    check("kill.lu_masked.idex",  32'(idex_flush), 32'd0);
    tick();
    check("lu.pc_en",      32'(pc_en),      32'd0);
    check("lu.ifid_en",    32'(ifid_en),    32'd0);
    check("lu.idex_flush", 32'(idex_flush), 32'd1);
    check("lu.ifid_flush", 32'(ifid_flush), 32'd0);
    tick();
    load_use = 1'b0; #1;
    check_cnt("lu", 15, 1, 1, 1);

    // Halt, then go held high: exactly one resume
    sys_halt = 1'b1; #1;
    check("hreq.pc_en",      32'(pc_en),      32'd0);
    check("hreq.ifid_en",    32'(ifid_en),    32'd0);
    check("hreq.ifid_flush", 32'(ifid_flush), 32'd0);
    check("hreq.idex_flush", 32'(idex_flush), 32'd0);
    check("hreq.halted",     32'(halted),     32'd0);
    tick();
    sys_halt = 1'b0; #1;
    check("halt.halted", 32'(halted), 32'd1);
    check("halt.pc_en",  32'(pc_en),  32'd0);
    tick();
    check_cnt("halt.frozen", 16, 1, 1, 1);
    go = 1'b1; #1;
    check("exit.halted", 32'(halted), 32'd1);
    check("exit.pc_en",  32'(pc_en),  32'd0);
    tick();
    check("resume.halted", 32'(halted), 32'd0);
    check("resume.pc_en",  32'(pc_en),  32'd1);
    check("resume.cyc",    cyc_cnt,     32'd16);
    tick();
    sys_halt = 1'b1; #1;
    check("rehalt.pc_en", 32'(pc_en), 32'd0);
    tick();
    sys_halt = 1'b0; #1;
    check("heldgo1.halted", 32'(halted), 32'd1);
    tick();
    check("heldgo2.halted", 32'(halted), 32'd1);
    check("heldgo2.cyc",    cyc_cnt,     32'd18);
    tick();
    go = 1'b0;
    tick();
    go = 1'b1; #1;
    check("exit2.halted", 32'(halted), 32'd1);
    tick();
    go = 1'b0; #1;
    check("resume2.halted", 32'(halted), 32'd0);
    check_cnt("resume2", 18, 1, 1, 1);

    // Reset asserted mid-halt
    sys_halt = 1'b1;
    tick();
    sys_halt = 1'b0; #1;
    check("midhalt.halted", 32'(halted), 32'd1);
    rst = 1'b1; #1;
    check("midhalt.rst.halted",     32'(halted),     32'd0);
    check("midhalt.rst.ifid_flush", 32'(ifid_flush), 32'd1);
    tick();
    rst = 1'b0; #1;
    check("postrst.halted", 32'(halted), 32'd0);
    check("postrst.pc_en",  32'(pc_en),  32'd1);
    check_cnt("postrst", 0, 0, 0, 0);

    // 17 load-use stalls wrap the 4-bit stall counter to 1
    load_use = 1'b1;
    repeat (17) tick();
    load_use = 1'b0; #1;
    check_cnt("wrap", 17, 0, 0, 1);

    // Branch is not masked by the kill cycle after a jump
    jmp = 1'b1; #1;
    tick();
    jmp = 1'b0; br_taken = 1'b1; #1;
    check("killbr.idex_flush", 32'(idex_flush), 32'd1);
    check("killbr.ifid_flush", 32'(ifid_flush), 32'd1);
    tick();
    br_taken = 1'b0; #1;
    check_cnt("killbr", 19, 1, 1, 1);

    // Reset asserted mid-flush
    br_taken = 1'b1; rst = 1'b1; #1;
    check("midflush.pc_en", 32'(pc_en),      32'd0);
    check("midflush.idex",  32'(idex_flush), 32'd1);
    tick();
    br_taken = 1'b0; rst = 1'b0; #1;
    check("postflush.ifid_flush", 32'(ifid_flush), 32'd0);
    check_cnt("postflush", 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
